nrisc_dmem_arbiter: RTL and testbench
=====================================

Name: nrisc_dmem_arbiter

Overview:
- Shares the single data memory port between the nRisc core's load/store path and a host/debug port (program loader, memory inspection).
- Sits between the core's EnderecoDados/DadoEscrito/DadoLido/MemRead/MemWrite and a synchronous-read data RAM with 1-cycle read latency.
- Stalls the single-cycle core through CoreStall, which gates PCWrite and RegWrite, while a read is in flight or while the host owns the port.

Parameters:
- HOST_WAIT_MAX, 4, cycles a pending host request may lose to the core before it wins the next arbitration (1..15).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- CoreRead  in  1  core load request (MemRead).
- CoreWrite  in  1  core store request (MemWrite).
- CoreAddr  in  ADDR_W  core address (EnderecoDados).
- CoreWData  in  DATA_W  core store data (DadoEscrito).
- CoreRData  out  DATA_W  load data to the core (DadoLido).
- CoreStall  out  1  core must hold PC and suppress register write this cycle.
- HostReq  in  1  host access request; held until HostGnt.
- HostWe  in  1  host request is a write.
- HostAddr  in  ADDR_W  host address.
- HostWData  in  DATA_W  host write data.
- HostGnt  out  1  1-cycle pulse: host access issued to memory this cycle.
- HostRData  out  DATA_W  registered host read data.
- HostValid  out  1  1-cycle pulse: HostRData valid.
- MemAddr  out  ADDR_W  RAM address.
- MemWData  out  DATA_W  RAM write data.
- MemWrite  out  1  RAM write strobe; RAM writes at the same rising edge.
- MemRead  out  1  RAM read strobe; MemRData is valid the next cycle.
- MemRData  in  DATA_W  RAM read data.

Behaviour:
- State machine: IDLE, CORE_RD, HOST_RD.
  - State register, StarveCnt, HostRData and HostValid are updated only on the rising edge of Clock.
  - Mem*, HostGnt, CoreStall and CoreRData are combinational from state and inputs.
- Reset == 0 at an edge:
  - state = IDLE, StarveCnt = 0, HostRData = 0, HostValid = 0.
  - While Reset is low: MemRead = MemWrite = HostGnt = CoreStall = 0, MemAddr = MemWData = 0.
  - Reset during CORE_RD or HOST_RD aborts the read; no HostValid is produced.
- Arbitration occurs only in IDLE.
  - CoreReq = CoreRead | CoreWrite. CoreRead and CoreWrite both high is treated as a write.
  - Core wins when CoreReq is high and (HostReq is low, or StarveCnt < HOST_WAIT_MAX).
  - Host wins when HostReq is high and (CoreReq is low, or StarveCnt == HOST_WAIT_MAX).
- Core write granted:
  - MemWrite = 1, MemAddr = CoreAddr, MemWData = CoreWData, CoreStall = 0.
  - Completes in 1 cycle; state stays IDLE.
- Core read granted:
  - MemRead = 1, MemAddr = CoreAddr, CoreStall = 1, next state CORE_RD.
- CORE_RD:
  - CoreRData = MemRData, CoreStall = 0, no memory strobe, next state IDLE.
  - The core's repeated request in this cycle is not reissued.
  - Every core load therefore costs 2 cycles.
- Host granted:
  - HostGnt = 1, MemAddr = HostAddr, StarveCnt cleared to 0.
  - CoreStall = 1 if CoreReq is high.
  - HostWe = 1: MemWrite = 1, MemWData = HostWData, state stays IDLE.
  - HostWe = 0: MemRead = 1, next state HOST_RD.
- HOST_RD:
  - HostRData <= MemRData and HostValid = 1 at the exiting edge (visible the following cycle).
  - CoreStall = CoreReq; next state IDLE.
- StarveCnt:
  - Increments (saturating at HOST_WAIT_MAX) on each IDLE cycle where HostReq = 1 and the host loses.
  - Holds in CORE_RD and HOST_RD.
- CoreRData = 0 outside CORE_RD.
- Idle, no requests: all strobes 0, CoreStall = 0.
- Worst-case host latency: 2*HOST_WAIT_MAX + 1 cycles from request to HostGnt.

Test Plan:
- Reset low 3 cycles with CoreRead = 1 and HostReq = 1 -> all strobes 0, CoreStall = 0, HostValid = 0. After release, core read of addr 0x10 (RAM[0x10] = 0xA5) -> cycle 1: MemRead = 1, CoreStall = 1; cycle 2: CoreRData = 0xA5, CoreStall = 0.
- Core write addr 0x22 data 0x3C -> MemWrite = 1 same cycle, CoreStall = 0. A following core read of 0x22 returns 0x3C.
- Host write 0x40 <= 0x77 with core idle -> HostGnt in the first cycle. Host read 0x40 -> HostGnt, then HostValid = 1 with HostRData = 0x77 two edges after the request.
- Core issues back-to-back writes continuously while HostReq is held, HOST_WAIT_MAX = 4 -> host loses 4 arbitrations, wins the 5th with CoreStall = 1 that cycle, StarveCnt returns to 0.
- Simultaneous CoreRead and CoreWrite to 0x05 data 0x11 -> treated as a write: MemWrite = 1, MemRead = 0.
- Reset asserted in the HOST_RD cycle of a host read -> HostValid never pulses, HostRData = 0, state IDLE.

Source files
------------

// File: rtl/nrisc_dmem_arbiter.sv
// Data-memory port arbiter for the nRisc core: shares one synchronous-read RAM
// between the core load/store path and a host/debug port, stalling the core as needed.
module nrisc_dmem_arbiter #(
    parameter int HOST_WAIT_MAX = 4,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CoreRead,
    input  logic              CoreWrite,
    input  logic [ADDR_W-1:0] CoreAddr,
    input  logic [DATA_W-1:0] CoreWData,
    output logic [DATA_W-1:0] CoreRData,
    output logic              CoreStall,
    input  logic              HostReq,
    input  logic              HostWe,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostGnt,
    output logic [DATA_W-1:0] HostRData,
    output logic              HostValid,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemRData
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        HOST_RD = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

    state_t     state_r;
    state_t     nextState_s;
    logic [3:0] starveCnt_r;
    logic [3:0] starveNext_s;
    logic       coreReq_s;
    logic       coreWins_s;
    logic       hostWins_s;

    // Request decode and priority: the host only overrides the core once starved.
    always_comb begin
        coreReq_s  = CoreRead | CoreWrite;
        coreWins_s = coreReq_s & (~HostReq | (starveCnt_r < WAIT_MAX));
        hostWins_s = HostReq & (~coreReq_s | (starveCnt_r == WAIT_MAX));
    end

    // Next-state, starvation counter and memory/handshake outputs.
    always_comb begin
        nextState_s  = state_r;
        starveNext_s = starveCnt_r;
        MemAddr      = {ADDR_W{1'b0}};
        MemWData     = {DATA_W{1'b0}};
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        HostGnt      = 1'b0;
        CoreStall    = 1'b0;
        CoreRData    = {DATA_W{1'b0}};
        if (!Reset) begin
            nextState_s  = IDLE;
            starveNext_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (coreWins_s) begin
                        MemAddr = CoreAddr;
                        // A simultaneous read and write is a write.
                        if (CoreWrite) begin
                            MemWrite = 1'b1;
                            MemWData = CoreWData;
                        end else begin
                            MemRead     = 1'b1;
                            CoreStall   = 1'b1;
                            nextState_s = CORE_RD;
                        end
                        if (HostReq && (starveCnt_r < WAIT_MAX)) begin
                            starveNext_s = starveCnt_r + 4'd1;
                        end else begin
                            starveNext_s = starveCnt_r;
                        end
                    end else if (hostWins_s) begin
                        HostGnt      = 1'b1;
                        MemAddr      = HostAddr;
                        CoreStall    = coreReq_s;
                        starveNext_s = 4'd0;
                        if (HostWe) begin
                            MemWrite = 1'b1;
                            MemWData = HostWData;
                        end else begin
                            MemRead     = 1'b1;
                            nextState_s = HOST_RD;
                        end
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                CORE_RD: begin
                    CoreRData   = MemRData;
                    nextState_s = IDLE;
                end
                HOST_RD: begin
                    CoreStall   = coreReq_s;
                    nextState_s = IDLE;
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end
    end

    // State, starvation counter and registered host read return.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r     <= IDLE;
            starveCnt_r <= 4'd0;
            HostRData   <= {DATA_W{1'b0}};
            HostValid   <= 1'b0;
        end else begin
            state_r     <= nextState_s;
            starveCnt_r <= starveNext_s;
            HostValid   <= (state_r == HOST_RD);
            if (state_r == HOST_RD) begin
                HostRData <= MemRData;
            end else begin
                HostRData <= HostRData;
            end
        end
    end

endmodule

// File: tb/tb_nrisc_dmem_arbiter.sv
// Scoreboard bench for nrisc_dmem_arbiter: stimulus queues per-cycle expectations,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_nrisc_dmem_arbiter;

    logic       Clock = 1'b1;
    logic       Reset;
    logic       CoreRead, CoreWrite, CoreStall;
    logic [7:0] CoreAddr, CoreWData, CoreRData;
    logic       HostReq, HostWe, HostGnt, HostValid;
    logic [7:0] HostAddr, HostWData, HostRData;
    logic [7:0] MemAddr, MemWData, MemRData;
    logic       MemWrite, MemRead;

    typedef struct {
        string      nm;
        logic       rd, wr, gnt, stall, hv, zero, chkHrd;
        logic [7:0] addr, wd, crd, hrd;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] hostQ[$];
    int         checks = 0;
    int         failures = 0;
    logic       done = 1'b0;
    logic [7:0] mem [256];

    always #5 Clock = ~Clock;

    nrisc_dmem_arbiter #(.HOST_WAIT_MAX(4), .ADDR_W(8), .DATA_W(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .CoreRead(CoreRead), .CoreWrite(CoreWrite), .CoreAddr(CoreAddr),
        .CoreWData(CoreWData), .CoreRData(CoreRData), .CoreStall(CoreStall),
        .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr),
        .HostWData(HostWData), .HostGnt(HostGnt), .HostRData(HostRData),
        .HostValid(HostValid), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemRData(MemRData)
    );

    // Synchronous-read RAM with one cycle of read latency.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h10] <= 8'hA5;
        MemRData   <= 8'h00;
    end
    always @(posedge Clock) begin
        if (MemWrite) mem[MemAddr] <= MemWData;
        if (MemRead) MemRData <= mem[MemAddr];
    end

    task automatic drv(input logic rst, input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [7:0] cwd,
                       input logic hr, input logic hwe,
                       input logic [7:0] ha, input logic [7:0] hwd);
        Reset = rst; CoreRead = cr; CoreWrite = cw; CoreAddr = ca; CoreWData = cwd;
        HostReq = hr; HostWe = hwe; HostAddr = ha; HostWData = hwd;
    endtask

    task automatic ex(input string nm, input logic rd, input logic wr,
                      input logic gnt, input logic stall,
                      input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] crd, input logic hv, input logic zero,
                      input logic chkHrd, input logic [7:0] hrd);
        exp_t e;
        e.nm = nm; e.rd = rd; e.wr = wr; e.gnt = gnt; e.stall = stall;
        e.addr = addr; e.wd = wd; e.crd = crd; e.hv = hv; e.zero = zero;
        e.chkHrd = chkHrd; e.hrd = hrd;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Stimulus: directed cycles with hand-computed expectations.
    initial begin
        logic [7:0] a, d, hd;
        drv(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        step();
        repeat (2) begin
            ex("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
            step();
        end
        drv(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("ldA_c1", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        ex("ldA_c2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b0, 1'b1, 8'h22, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("st22", 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("ld22_c1", 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        ex("ld22_c2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77);
        ex("hwr40", 1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        hostQ.push_back(8'h77);
        ex("hrd40_gnt", 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        // Core asks for a load while the host read is in flight: it must stall.
        drv(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("hrd40_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        ex("hrd40_valid", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
        step();
        ex("ldB_c2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                a  = 8'h80 + 8'(r * 5 + i);
                d  = 8'(i);
                hd = (r == 0) ? 8'h99 : 8'hAA;
                drv(1'b1, 1'b0, 1'b1, a, d, 1'b1, 1'b1, 8'h41, hd);
                if (i < 4) begin
                    ex("starve_core", 1'b0, 1'b1, 1'b0, 1'b0, a, d, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
                end else begin
                    ex("starve_host", 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, hd, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
                end
                step();
            end
        end
        drv(1'b1, 1'b1, 1'b1, 8'h05, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("rdwr", 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00);
        ex("abort_gnt", 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77);
        step();
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        step();
        drv(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        ex("abort_ld_c1", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        step();
        ex("abort_ld_c2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        done = 1'b1;
    end

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
        end
    endtask

    // Monitor: pops expectations and host read returns on the falling edge.
    initial begin
        exp_t       e;
        logic [7:0] h;
        forever begin
            @(negedge Clock);
            if (done) break;
            if (HostValid === 1'b1) begin
                if (hostQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL hostValid_unexpected actual=1 expected=0");
                end else begin
                    h = hostQ.pop_front();
                    cmp("hostRData_sb", HostRData, h);
                end
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                cmp({e.nm, ".MemRead"},   {7'd0, MemRead},   {7'd0, e.rd});
                cmp({e.nm, ".MemWrite"},  {7'd0, MemWrite},  {7'd0, e.wr});
                cmp({e.nm, ".HostGnt"},   {7'd0, HostGnt},   {7'd0, e.gnt});
                cmp({e.nm, ".CoreStall"}, {7'd0, CoreStall}, {7'd0, e.stall});
                cmp({e.nm, ".HostValid"}, {7'd0, HostValid}, {7'd0, e.hv});
                cmp({e.nm, ".CoreRData"}, CoreRData, e.crd);
                if (e.rd || e.wr || e.zero) cmp({e.nm, ".MemAddr"}, MemAddr, e.addr);
                if (e.wr || e.zero) cmp({e.nm, ".MemWData"}, MemWData, e.wd);
                if (e.chkHrd) cmp({e.nm, ".HostRData"}, HostRData, e.hrd);
            end
        end
        cmp("hostQ_drained", 8'(hostQ.size()), 8'd0);
        cmp("expQ_drained", 8'(expQ.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
